// File: rtl/bzone_input_pkg.sv
// Shared types and constants for the Battlezone / Bradley / Red Baron input conditioner.
package bzone_input_pkg;

    typedef enum logic [1:0] {
        MOD_BZ       = 2'd0,
        MOD_BRADLEY  = 2'd1,
        MOD_REDBARON = 2'd2
    } mod_e;

    // Bit positions inside the raw MiSTer joystick word
    localparam int J_R      = 0;
    localparam int J_L      = 1;
    localparam int J_D      = 2;
    localparam int J_U      = 3;
    localparam int J_FIRE   = 4;
    localparam int J_START1 = 5;
    localparam int J_START2 = 6;
    localparam int J_COIN   = 7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PULSE    = 2'd1,
        GAP      = 2'd2,
        WAIT_REL = 2'd3
    } coin_st_e;

    // Tread commands {W_fw, W_bk, X_fw, X_bk}
    localparam logic [3:0] TR_U    = 4'b1010;
    localparam logic [3:0] TR_UL   = 4'b0010;
    localparam logic [3:0] TR_UR   = 4'b1000;
    localparam logic [3:0] TR_R    = 4'b1001;
    localparam logic [3:0] TR_DR   = 4'b0100;
    localparam logic [3:0] TR_D    = 4'b0101;
    localparam logic [3:0] TR_DL   = 4'b0001;
    localparam logic [3:0] TR_L    = 4'b0110;
    localparam logic [3:0] TR_NONE = 4'b0000;

    // {U,D,L,R} -> tread command; opposing or absent directions stop both treads
    function automatic logic [3:0] tread_map(input logic [3:0] udlr);
        case (udlr)
            4'b1000: tread_map = TR_U;
            4'b1010: tread_map = TR_UL;
            4'b1001: tread_map = TR_UR;
            4'b0001: tread_map = TR_R;
            4'b0101: tread_map = TR_DR;
            4'b0100: tread_map = TR_D;
            4'b0110: tread_map = TR_DL;
            4'b0010: tread_map = TR_L;
            default: tread_map = TR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/bzone_debounce.sv
// One-bit two-flop synchroniser followed by a stable-time debouncer.
module bzone_debounce
#(
    parameter int DB_CYCLES = 250000
)
(
    input  logic clk_i,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int              CW     = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_TC = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Bring the asynchronous switch into the clock domain
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has been stable for DB_CYCLES cycles
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (sync2 == dout) begin
            cnt <= '0;
        end else if (cnt == CNT_TC) begin
            cnt  <= '0;
            dout <= sync2;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bzone_input_ctrl.sv
// Cabinet input conditioner: debounce, tread map, coin pulse shaper, Red Baron analog mux.
// Optional feature: define BZ_AUTOFIRE_EN to make a held fire button toggle every AF_HALF cycles.
//
// Coin FSM
//   state    | meaning
//   IDLE     | waiting for a rising edge of the debounced coin switch
//   PULSE    | coin output active for COIN_CYCLES cycles
//   GAP      | coin output forced inactive for COIN_GAP cycles, presses ignored
//   WAIT_REL | waiting for the coin switch to be released
module bzone_input_ctrl
    import bzone_input_pkg::*;
#(
    parameter int DB_CYCLES   = 250000,
    parameter int COIN_CYCLES = 2500000,
    parameter int COIN_GAP    = 2500000,
    parameter int AF_HALF     = 5000000
)
(
    input  logic        clk_i,
    input  logic        btnCpuReset,
    input  logic [15:0] joy_i,
    input  logic [15:0] joya_i,
    input  logic [1:0]  mod_i,
    input  logic        audiosel_i,
    output logic [7:0]  JB_o,
    output logic [7:0]  buttons_o,
    output logic [7:0]  redbaron_btn_o
);

    localparam int TMAX = (COIN_CYCLES > COIN_GAP) ? COIN_CYCLES : COIN_GAP;
    localparam int TW   = $clog2(TMAX + 1);

    logic [7:0]    db;
    logic [1:0]    mod_q;
    logic          mod_chg;
    logic          is_rb;
    coin_st_e      coin_st, coin_st_nxt;
    logic [TW-1:0] coin_tmr, coin_tmr_nxt;
    logic          coin_prev;
    logic          coin_q_nxt;
    logic          fire_eff;
    logic [3:0]    tread;
    logic [7:0]    jb_nxt, btn_nxt, rb_nxt;
    logic          unused_joy_hi;

    assign unused_joy_hi = ^joy_i[15:8];

    for (genvar gi = 0; gi < 8; gi++) begin : g_db
        bzone_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk_i (clk_i),
            .rst_n (btnCpuReset),
            .din   (joy_i[gi]),
            .dout  (db[gi])
        );
    end

    assign mod_chg = (mod_i != mod_q);
    assign is_rb   = (mod_i == MOD_REDBARON);

    // Coin FSM state, its down-counting timer and edge-detect history
    always_ff @(posedge clk_i or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            coin_st   <= IDLE;
            coin_tmr  <= '0;
            coin_prev <= 1'b0;
            mod_q     <= MOD_BZ;
        end else begin
            coin_st   <= coin_st_nxt;
            coin_tmr  <= coin_tmr_nxt;
            coin_prev <= db[J_COIN];
            mod_q     <= mod_i;
        end
    end

    // Coin FSM next state; a game-mode change drops any pulse in progress
    always_comb begin
        coin_st_nxt  = coin_st;
        coin_tmr_nxt = coin_tmr;
        case (coin_st)
            IDLE: begin
                if (db[J_COIN] && !coin_prev) begin
                    coin_st_nxt  = PULSE;
                    coin_tmr_nxt = TW'(COIN_CYCLES - 1);
                end
            end
            PULSE: begin
                if (coin_tmr == '0) begin
                    coin_st_nxt  = GAP;
                    coin_tmr_nxt = TW'(COIN_GAP - 1);
                end else begin
                    coin_tmr_nxt = coin_tmr - 1'b1;
                end
            end
            GAP: begin
                if (coin_tmr == '0) begin
                    coin_st_nxt = WAIT_REL;
                end else begin
                    coin_tmr_nxt = coin_tmr - 1'b1;
                end
            end
            WAIT_REL: begin
                if (!db[J_COIN]) begin
                    coin_st_nxt = IDLE;
                end
            end
            default: begin
                coin_st_nxt = IDLE;
            end
        endcase
        if (mod_chg) begin
            coin_st_nxt  = IDLE;
            coin_tmr_nxt = '0;
        end
    end

    // Coin output is taken from the next state so it lines up with the other registered outputs
    assign coin_q_nxt = (coin_st_nxt == PULSE);

`ifdef BZ_AUTOFIRE_EN
    localparam int            AW    = $clog2(AF_HALF + 1);
    localparam logic [AW-1:0] AF_TC = AW'(AF_HALF - 1);

    logic [AW-1:0] af_cnt;
    logic          af_ph;

    // Autofire half-period timer; phase restarts high on every new press
    always_ff @(posedge clk_i or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            af_cnt <= '0;
            af_ph  <= 1'b1;
        end else if (!db[J_FIRE] || mod_chg) begin
            af_cnt <= '0;
            af_ph  <= 1'b1;
        end else if (af_cnt == AF_TC) begin
            af_cnt <= '0;
            af_ph  <= ~af_ph;
        end else begin
            af_cnt <= af_cnt + 1'b1;
        end
    end

    assign fire_eff = db[J_FIRE] & af_ph;
`else
    localparam int AF_HALF_UNUSED = AF_HALF;

    assign fire_eff = db[J_FIRE];
`endif

    assign tread = tread_map({db[J_U], db[J_D], db[J_L], db[J_R]});

    // Per-game output byte mapping
    always_comb begin
        jb_nxt  = 8'h00;
        btn_nxt = 8'h00;
        rb_nxt  = 8'h00;
        if (is_rb) begin
            jb_nxt  = {~coin_q_nxt, db[J_START1], db[J_START2], fire_eff,
                       db[J_D], db[J_U], db[J_R], db[J_L]};
            btn_nxt = 8'd128 + (audiosel_i ? joya_i[7:0] : joya_i[15:8]);
            rb_nxt  = {fire_eff, db[J_START1], 6'b000000};
        end else begin
            jb_nxt  = {coin_q_nxt, db[J_START1], db[J_START2], fire_eff, tread};
            btn_nxt = {2'b00, db[J_START1], db[J_START2] | fire_eff, tread};
        end
    end

    // Output registers
    always_ff @(posedge clk_i or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            JB_o           <= 8'h00;
            buttons_o      <= 8'h00;
            redbaron_btn_o <= 8'h00;
        end else begin
            JB_o           <= jb_nxt;
            buttons_o      <= btn_nxt;
            redbaron_btn_o <= rb_nxt;
        end
    end

endmodule

// File: tb/tb_bzone_input_ctrl.sv
// Directed self-checking bench for bzone_input_ctrl (short timing parameters).
module tb_bzone_input_ctrl;

    logic        clk_i = 1'b0;
    logic        btnCpuReset;
    logic [15:0] joy_i;
    logic [15:0] joya_i;
    logic [1:0]  mod_i;
    logic        audiosel_i;
    logic [7:0]  JB_o;
    logic [7:0]  buttons_o;
    logic [7:0]  redbaron_btn_o;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   coin_highs;
    int   coin_rises;
    logic coin_last;

    // Direction / button vectors with hand-computed mod-0 outputs
    logic [15:0] vec_joy [13] = '{16'h0001, 16'h0003, 16'h0002, 16'h0004, 16'h0005,
                                  16'h0006, 16'h0009, 16'h000A, 16'h000C, 16'h0010,
                                  16'h0020, 16'h0040, 16'h0062};
    logic [7:0]  vec_jb  [13] = '{8'h09, 8'h00, 8'h06, 8'h05, 8'h04,
                                  8'h01, 8'h08, 8'h02, 8'h00, 8'h10,
                                  8'h40, 8'h20, 8'h66};
    logic [7:0]  vec_btn [13] = '{8'h09, 8'h00, 8'h06, 8'h05, 8'h04,
                                  8'h01, 8'h08, 8'h02, 8'h00, 8'h10,
                                  8'h20, 8'h10, 8'h36};

    bzone_input_ctrl #(
        .DB_CYCLES   (4),
        .COIN_CYCLES (10),
        .COIN_GAP    (6),
        .AF_HALF     (5)
    ) dut (
        .clk_i          (clk_i),
        .btnCpuReset    (btnCpuReset),
        .joy_i          (joy_i),
        .joya_i         (joya_i),
        .mod_i          (mod_i),
        .audiosel_i     (audiosel_i),
        .JB_o           (JB_o),
        .buttons_o      (buttons_o),
        .redbaron_btn_o (redbaron_btn_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic mon_coin(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (JB_o[7]) coin_highs++;
            if (JB_o[7] && !coin_last) coin_rises++;
            coin_last = JB_o[7];
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          first_hi;
        int          hi_cnt;
        logic [7:0]  exp_f;

        // 1. Reset
        btnCpuReset = 1'b0;
        joy_i       = 16'hFFFF;
        joya_i      = 16'h0000;
        mod_i       = 2'd0;
        audiosel_i  = 1'b0;
        tick(3);
        chk("rst_jb",  JB_o,           8'h00);
        chk("rst_btn", buttons_o,      8'h00);
        chk("rst_rb",  redbaron_btn_o, 8'h00);
        btnCpuReset = 1'b1;
        tick(6);
        chk("post_rst_jb",  JB_o,      8'h00);
        chk("post_rst_btn", buttons_o, 8'h00);
        tick(1);
        chk("all_on_jb",  JB_o,      8'hF0);
        chk("all_on_btn", buttons_o, 8'h30);
        joy_i = 16'h0000;
        tick(40);

        // 2. Debounce and tread map
        joy_i = 16'h0008;
        tick(3);
        joy_i = 16'h0000;
        tick(10);
        chk("glitch_jb",  JB_o,      8'h00);
        chk("glitch_btn", buttons_o, 8'h00);
        joy_i = 16'h0008;
        tick(6);
        chk("u_early_jb", JB_o, 8'h00);
        tick(1);
        chk("u_jb",  JB_o,      8'h0A);
        chk("u_btn", buttons_o, 8'h0A);
        tick(1);
        for (int v = 0; v < 13; v++) begin
            joy_i = vec_joy[v];
            tick(7);
            chk("vec_jb",  JB_o,      vec_jb[v]);
            chk("vec_btn", buttons_o, vec_btn[v]);
        end
        joy_i = 16'h0000;
        tick(10);

        // 3. Coin pulse
        first_hi = 0;
        hi_cnt   = 0;
        joy_i    = 16'h0080;
        for (int i = 1; i <= 100; i++) begin
            tick(1);
            if (JB_o[7]) begin
                if (first_hi == 0) first_hi = i;
                hi_cnt++;
            end
        end
        chk("coin_first", 8'(first_hi), 8'd7);
        chk("coin_width", 8'(hi_cnt),   8'd10);
        joy_i = 16'h0000;
        tick(20);

        coin_highs = 0;
        coin_rises = 0;
        coin_last  = 1'b0;
        joy_i = 16'h0080;
        mon_coin(8);
        joy_i = 16'h0000;
        mon_coin(6);
        joy_i = 16'h0080;
        mon_coin(40);
        chk("gap_press_rises", 8'(coin_rises), 8'd1);
        chk("gap_press_highs", 8'(coin_highs), 8'd10);
        joy_i = 16'h0000;
        mon_coin(20);
        coin_highs = 0;
        coin_rises = 0;
        joy_i = 16'h0080;
        mon_coin(30);
        chk("repress_rises", 8'(coin_rises), 8'd1);
        chk("repress_highs", 8'(coin_highs), 8'd10);
        joy_i = 16'h0000;
        tick(20);

        // 4. Red Baron analog
        mod_i      = 2'd2;
        joya_i     = 16'h7F80;
        audiosel_i = 1'b1;
        tick(1);
        chk("rb_x_btn", buttons_o,      8'h00);
        chk("rb_jb",    JB_o,           8'h80);
        chk("rb_rbtn",  redbaron_btn_o, 8'h00);
        audiosel_i = 1'b0;
        tick(1);
        chk("rb_y_btn", buttons_o, 8'hFF);
        joya_i = 16'h0000;
        tick(1);
        chk("rb_zero_btn", buttons_o, 8'h80);
        joy_i = 16'h0009;
        tick(7);
        chk("rb_dir_jb", JB_o, 8'h86);
        joy_i = 16'h0000;
        tick(10);

        // 5. Mode change during a coin pulse
        mod_i = 2'd0;
        tick(2);
        joy_i = 16'h00B0;
        tick(9);
        chk("pulse_bz_jb", JB_o, 8'hD0);
        mod_i = 2'd2;
        tick(1);
        chk("abort_jb",   JB_o,           8'hD0);
        chk("abort_rbtn", redbaron_btn_o, 8'hC0);
        tick(5);
        chk("abort_hold_jb", JB_o, 8'hD0);
        mod_i = 2'd0;
        tick(1);
        chk("no_repulse_jb", JB_o, 8'h50);
        joy_i = 16'h0000;
        tick(20);

        // 6. Fire (autofire when enabled)
        joy_i = 16'h0010;
        for (int c = 1; c <= 45; c++) begin
            tick(1);
            if (c >= 7 && c <= 39) begin
`ifdef BZ_AUTOFIRE_EN
                exp_f = ((((c - 7) / 5) % 2) == 0) ? 8'h10 : 8'h00;
`else
                exp_f = 8'h10;
`endif
            end else begin
                exp_f = 8'h00;
            end
            chk("fire_jb", JB_o & 8'h10, exp_f);
            if (c == 33) joy_i = 16'h0000;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
